// File: rtl/mosse_video_pkg.sv
// Shared beat-level types and constants for the MOSSE tracker video pipeline.
// A beat carries four 8-bit gray pixels, pixel 0 in the low byte.
package mosse_video_pkg;

  localparam int PPC    = 4;
  localparam int PIX_W  = 8;
  localparam int BEAT_W = PPC * PIX_W;

  typedef struct packed {
    logic [BEAT_W-1:0] tdata;
    logic              tuser;
    logic              tlast;
  } video_beat_t;

  // Extracts pixel idx from a packed beat.
  function automatic logic [PIX_W-1:0] beat_pixel(input logic [BEAT_W-1:0] beat,
                                                  input int unsigned idx);
    return beat[idx*PIX_W +: PIX_W];
  endfunction

endpackage

// File: rtl/axis_skid_buffer.sv
// Two-entry AXI-Stream skid buffer with a registered upstream ready.
// The head entry drives the outputs directly, so data and flags hold while stalled.
module axis_skid_buffer #(
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              s_valid_i,
  input  logic [DATA_W-1:0] s_data_i,
  output logic              s_ready_o,
  output logic              m_valid_o,
  output logic [DATA_W-1:0] m_data_o,
  input  logic              m_ready_i
);

  logic [DATA_W-1:0] head_q, head_d;
  logic [DATA_W-1:0] tail_q, tail_d;
  logic [1:0]        count_q, count_d;
  logic              ready_q;
  logic              push;
  logic              pop;

  assign push      = s_valid_i && ready_q;
  assign pop       = m_valid_o && m_ready_i;
  assign s_ready_o = ready_q;
  assign m_valid_o = (count_q != 2'd0);
  assign m_data_o  = head_q;

  // When both entries are live, a pop promotes tail to head and a push refills tail.
  always_comb begin
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    case (count_q)
      2'd0: begin
        if (push) begin
          head_d  = s_data_i;
          count_d = 2'd1;
        end
      end
      2'd1: begin
        if (push && pop) begin
          head_d = s_data_i;
        end else if (push) begin
          tail_d  = s_data_i;
          count_d = 2'd2;
        end else if (pop) begin
          count_d = 2'd0;
        end
      end
      default: begin
        if (pop) begin
          head_d = tail_q;
          if (push) begin
            tail_d = s_data_i;
          end else begin
            count_d = 2'd1;
          end
        end
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= 2'd0;
      ready_q <= 1'b1;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
      ready_q <= (count_d != 2'd2);
    end
  end

endmodule

// File: rtl/gray_roi_crop_4ppc.sv
// Crops a programmable ROI out of 4-pixel-per-clock gray video and re-frames it
// as a standalone sub-frame with its own SOF/EOL markers behind a skid buffer.
module gray_roi_crop_4ppc
  import mosse_video_pkg::*;
#(
  parameter int X_W = 10,
  parameter int Y_W = 12
) (
  input  logic              s_axis_video_aclk,
  input  logic              s_axis_video_aresetn,
  input  logic [BEAT_W-1:0] VIDEO_IN_tdata,
  input  logic              VIDEO_IN_tvalid,
  input  logic              VIDEO_IN_tuser,
  input  logic              VIDEO_IN_tlast,
  output logic              VIDEO_IN_tready,
  output logic [BEAT_W-1:0] VIDEO_OUT_tdata,
  output logic              VIDEO_OUT_tvalid,
  output logic              VIDEO_OUT_tuser,
  output logic              VIDEO_OUT_tlast,
  input  logic              VIDEO_OUT_tready,
  input  logic [X_W-1:0]    ROI_X,
  input  logic [Y_W-1:0]    ROI_Y,
  input  logic [X_W-1:0]    ROI_W,
  input  logic [Y_W-1:0]    ROI_H,
  output logic              roi_done
);

  localparam int XS_W = X_W + 1;
  localparam int YS_W = Y_W + 1;

  typedef enum logic {
    WAIT_SOF = 1'b0,
    ACTIVE   = 1'b1
  } crop_state_e;

  typedef struct packed {
    video_beat_t beat;
    logic        done;
  } crop_item_t;

  crop_state_e    state_q;
  logic [X_W-1:0] col_q;
  logic [Y_W-1:0] line_q;
  logic [X_W-1:0] roiX_q, roiW_q;
  logic [Y_W-1:0] roiY_q, roiH_q;
  logic           sofPending_q;

  logic           inReady;
  logic           inAccept;
  logic           isSof;
  logic           inFrame;
  logic [X_W-1:0] curCol, curRoiX, curRoiW;
  logic [Y_W-1:0] curLine, curRoiY, curRoiH;
  logic [XS_W-1:0] colEnd;
  logic [YS_W-1:0] lineEnd;
  logic           colIn;
  logic           lineIn;
  logic           inRoi;
  logic           beatUser;
  logic           beatLast;
  logic           beatDone;
  crop_item_t     pushItem;
  crop_item_t     outItem;

  assign inAccept = VIDEO_IN_tvalid && inReady;
  assign isSof    = VIDEO_IN_tuser;
  assign inFrame  = isSof || (state_q == ACTIVE);

  // A SOF beat is itself col 0 / line 0 and is judged against the ROI it latches.
  assign curCol  = isSof ? '0 : col_q;
  assign curLine = isSof ? '0 : line_q;
  assign curRoiX = isSof ? ROI_X : roiX_q;
  assign curRoiW = isSof ? ROI_W : roiW_q;
  assign curRoiY = isSof ? ROI_Y : roiY_q;
  assign curRoiH = isSof ? ROI_H : roiH_q;

  assign colEnd  = {1'b0, curRoiX} + {1'b0, curRoiW};
  assign lineEnd = {1'b0, curRoiY} + {1'b0, curRoiH};
  assign colIn   = (curCol >= curRoiX) && ({1'b0, curCol} < colEnd);
  assign lineIn  = (curLine >= curRoiY) && ({1'b0, curLine} < lineEnd);
  assign inRoi   = inFrame && colIn && lineIn;

  assign beatUser = isSof || sofPending_q;
  assign beatLast = (({1'b0, curCol} + XS_W'(1)) == colEnd) || VIDEO_IN_tlast;
  assign beatDone = (({1'b0, curLine} + YS_W'(1)) == lineEnd) && beatLast;

  assign pushItem.beat.tdata = VIDEO_IN_tdata;
  assign pushItem.beat.tuser = beatUser;
  assign pushItem.beat.tlast = beatLast;
  assign pushItem.done       = beatDone;

  // Frame tracking; dropped beats still advance the position once a SOF has been seen.
  always_ff @(posedge s_axis_video_aclk or negedge s_axis_video_aresetn) begin
    if (!s_axis_video_aresetn) begin
      state_q      <= WAIT_SOF;
      col_q        <= '0;
      line_q       <= '0;
      roiX_q       <= '0;
      roiW_q       <= '0;
      roiY_q       <= '0;
      roiH_q       <= '0;
      sofPending_q <= 1'b0;
    end else if (inAccept && inFrame) begin
      state_q <= ACTIVE;
      if (VIDEO_IN_tlast) begin
        col_q  <= '0;
        line_q <= curLine + Y_W'(1);
      end else begin
        col_q  <= curCol + X_W'(1);
        line_q <= curLine;
      end
      if (isSof) begin
        roiX_q <= ROI_X;
        roiW_q <= ROI_W;
        roiY_q <= ROI_Y;
        roiH_q <= ROI_H;
      end
      sofPending_q <= beatUser && !inRoi;
    end
  end

  axis_skid_buffer #(
    .DATA_W($bits(crop_item_t))
  ) u_skid (
    .clk      (s_axis_video_aclk),
    .rst_n    (s_axis_video_aresetn),
    .s_valid_i(inAccept && inRoi),
    .s_data_i (pushItem),
    .s_ready_o(inReady),
    .m_valid_o(VIDEO_OUT_tvalid),
    .m_data_o (outItem),
    .m_ready_i(VIDEO_OUT_tready)
  );

  assign VIDEO_IN_tready  = inReady;
  assign VIDEO_OUT_tdata  = outItem.beat.tdata;
  assign VIDEO_OUT_tuser  = outItem.beat.tuser;
  assign VIDEO_OUT_tlast  = outItem.beat.tlast;
  assign roi_done         = VIDEO_OUT_tvalid && VIDEO_OUT_tready && outItem.done;

endmodule

// File: tb/tb_gray_roi_crop_4ppc.sv
// Self-checking bench for gray_roi_crop_4ppc: random pixel data and backpressure
// checked against a frame-level ROI model and an output scoreboard.
module tb_gray_roi_crop_4ppc;

  localparam int X_W = 10;
  localparam int Y_W = 12;

  logic           clk = 1'b0;
  logic           rstN = 1'b0;
  logic [31:0]    inData = '0;
  logic           inValid = 1'b0;
  logic           inUser = 1'b0;
  logic           inLast = 1'b0;
  logic           inReady;
  logic [31:0]    outData;
  logic           outValid;
  logic           outUser;
  logic           outLast;
  logic           outReady = 1'b1;
  logic [X_W-1:0] roiX = '0;
  logic [Y_W-1:0] roiY = '0;
  logic [X_W-1:0] roiW = '0;
  logic [Y_W-1:0] roiH = '0;
  logic           roiDone;

  always #5 clk = ~clk;

  gray_roi_crop_4ppc #(.X_W(X_W), .Y_W(Y_W)) dut (
    .s_axis_video_aclk   (clk),
    .s_axis_video_aresetn(rstN),
    .VIDEO_IN_tdata      (inData),
    .VIDEO_IN_tvalid     (inValid),
    .VIDEO_IN_tuser      (inUser),
    .VIDEO_IN_tlast      (inLast),
    .VIDEO_IN_tready     (inReady),
    .VIDEO_OUT_tdata     (outData),
    .VIDEO_OUT_tvalid    (outValid),
    .VIDEO_OUT_tuser     (outUser),
    .VIDEO_OUT_tlast     (outLast),
    .VIDEO_OUT_tready    (outReady),
    .ROI_X               (roiX),
    .ROI_Y               (roiY),
    .ROI_W               (roiW),
    .ROI_H               (roiH),
    .roi_done            (roiDone)
  );

  typedef struct {
    logic [31:0] d;
    logic        u;
    logic        l;
    logic        dn;
  } exp_t;

  exp_t        expQ[$];
  exp_t        curExp;
  int          testsRun = 0;
  int          failCount = 0;
  int          outBeats = 0;
  int          doneCount = 0;
  int          stallCycles = 0;
  int          readyMode = 0;
  bit          gapMode = 1'b0;
  logic        stalled = 1'b0;
  logic [31:0] heldData;
  logic        heldUser;
  logic        heldLast;

  // Downstream ready: 0 = always ready, 1 = random 50%, 2 = held low
  initial begin
    forever begin
      @(posedge clk);
      #1;
      case (readyMode)
        0:       outReady = 1'b1;
        1:       outReady = 1'($urandom_range(0, 1));
        default: outReady = 1'b0;
      endcase
    end
  end

  // Output scoreboard plus hold-while-stalled checking
  initial begin
    forever begin
      @(negedge clk);
      if (!rstN) begin
        stalled = 1'b0;
      end else begin
        if (stalled) begin
          testsRun++;
          if (outValid !== 1'b1 || outData !== heldData || outUser !== heldUser || outLast !== heldLast) begin
            failCount++;
            $display("[TB] FAIL stall_hold: got v=%b d=%h u=%b l=%b, need v=1 d=%h u=%b l=%b",
                     outValid, outData, outUser, outLast, heldData, heldUser, heldLast);
          end
        end
        if (roiDone === 1'b1 && !(outValid === 1'b1 && outReady === 1'b1)) begin
          testsRun++;
          failCount++;
          $display("[TB] FAIL done_without_handshake: roi_done=1 with v=%b r=%b", outValid, outReady);
        end
        if (outValid === 1'b1 && outReady === 1'b1) begin
          outBeats++;
          if (roiDone === 1'b1) doneCount++;
          testsRun++;
          if (expQ.size() == 0) begin
            failCount++;
            $display("[TB] FAIL unexpected_beat: got d=%h u=%b l=%b done=%b, expected no beat",
                     outData, outUser, outLast, roiDone);
          end else begin
            curExp = expQ.pop_front();
            if (outData !== curExp.d || outUser !== curExp.u || outLast !== curExp.l || roiDone !== curExp.dn) begin
              failCount++;
              $display("[TB] FAIL out_beat: got d=%h u=%b l=%b done=%b, need d=%h u=%b l=%b done=%b",
                       outData, outUser, outLast, roiDone, curExp.d, curExp.u, curExp.l, curExp.dn);
            end
          end
        end
        stalled  = (outValid === 1'b1 && outReady !== 1'b1);
        heldData = outData;
        heldUser = outUser;
        heldLast = outLast;
      end
    end
  end

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation time limit reached, need completion");
    $display("[TB] %0d tests run, %0d failed", testsRun, failCount + 1);
    $fatal(1, "[TB] watchdog");
  end

  task automatic sendBeat(input logic [31:0] d, input logic u, input logic l);
    int waitCycles = 0;
    if (gapMode && $urandom_range(0, 3) == 0) begin
      @(posedge clk);
      #1;
    end
    inValid = 1'b1;
    inData  = d;
    inUser  = u;
    inLast  = l;
    forever begin
      @(negedge clk);
      if (inReady === 1'b1) begin
        @(posedge clk);
        #1;
        break;
      end
      stallCycles++;
      waitCycles++;
      if (waitCycles > 500) begin
        testsRun++;
        failCount++;
        $display("[TB] FAIL in_ready_timeout: tready=%b after %0d cycles, need 1", inReady, waitCycles);
        break;
      end
      @(posedge clk);
      #1;
    end
    inValid = 1'b0;
    inUser  = 1'b0;
    inLast  = 1'b0;
  endtask

  // Sends a frame and queues the expected crop, computed from the ROI rectangle directly
  task automatic sendFrame(input int fw, input int fh, input int rx, input int ry,
                           input int rw, input int rh,
                           input int abortLine = -1, input int abortCol = -1);
    bit          first = 1'b1;
    logic [31:0] d;
    exp_t        e;
    roiX = X_W'(rx);
    roiY = Y_W'(ry);
    roiW = X_W'(rw);
    roiH = Y_W'(rh);
    for (int ln = 0; ln < fh; ln++) begin
      for (int c = 0; c < fw; c++) begin
        if (ln == abortLine && c == abortCol) return;
        d = $urandom;
        if (c >= rx && c < rx + rw && ln >= ry && ln < ry + rh) begin
          e.d   = d;
          e.u   = first;
          first = 1'b0;
          e.l   = (c == rx + rw - 1) || (c == fw - 1);
          e.dn  = e.l && (ln == ry + rh - 1);
          expQ.push_back(e);
        end
        sendBeat(d, (ln == 0 && c == 0), (c == fw - 1));
        if (ln == 0 && c == 0) begin
          roiX = X_W'($urandom);
          roiY = Y_W'($urandom);
          roiW = X_W'($urandom);
          roiH = Y_W'($urandom);
        end
      end
    end
  endtask

  task automatic drainOut(input string tag);
    int n = 0;
    while ((expQ.size() != 0 || outValid === 1'b1) && n < 400) begin
      @(posedge clk);
      #1;
      n++;
    end
    testsRun++;
    if (expQ.size() != 0 || outValid !== 1'b0) begin
      failCount++;
      $display("[TB] FAIL drain_%s: %0d beats still expected, tvalid=%b, need 0 and 0", tag, expQ.size(), outValid);
    end
  endtask

  task automatic checkCounts(input string tag, input int beatsNeed, input int donesNeed);
    testsRun++;
    if (outBeats !== beatsNeed || doneCount !== donesNeed) begin
      failCount++;
      $display("[TB] FAIL count_%s: got beats=%0d dones=%0d, need beats=%0d dones=%0d",
               tag, outBeats, doneCount, beatsNeed, donesNeed);
    end
    outBeats  = 0;
    doneCount = 0;
  endtask

  task automatic test_reset();
    #12;
    testsRun++;
    if (outValid !== 1'b0 || outData !== 32'h0 || outUser !== 1'b0 || outLast !== 1'b0 ||
        roiDone !== 1'b0 || inReady !== 1'b1) begin
      failCount++;
      $display("[TB] FAIL reset_values: got v=%b d=%h u=%b l=%b done=%b rdy=%b, need 0 0 0 0 0 1",
               outValid, outData, outUser, outLast, roiDone, inReady);
    end
    @(negedge clk);
    rstN = 1'b1;
    @(posedge clk);
    #1;
    testsRun++;
    if (inReady !== 1'b1 || outValid !== 1'b0) begin
      failCount++;
      $display("[TB] FAIL after_reset: got rdy=%b v=%b, need rdy=1 v=0", inReady, outValid);
    end
  endtask

  task automatic test_latency();
    exp_t        e;
    logic [31:0] d;
    readyMode = 0;
    gapMode   = 1'b0;
    d = $urandom;
    roiX = '0; roiY = '0; roiW = X_W'(1); roiH = Y_W'(1);
    e.d = d; e.u = 1'b1; e.l = 1'b1; e.dn = 1'b1;
    expQ.push_back(e);
    sendBeat(d, 1'b1, 1'b1);
    testsRun++;
    if (outValid !== 1'b1 || outData !== d) begin
      failCount++;
      $display("[TB] FAIL latency: got v=%b d=%h one cycle after accept, need v=1 d=%h", outValid, outData, d);
    end
    drainOut("latency");
    checkCounts("latency", 1, 1);
  endtask

  task automatic test_basic();
    readyMode = 0;
    gapMode   = 1'b0;
    sendFrame(8, 4, 2, 1, 3, 2);
    drainOut("basic");
    checkCounts("basic", 6, 1);
  endtask

  task automatic test_backpressure();
    readyMode = 1;
    gapMode   = 1'b1;
    sendFrame(8, 4, 2, 1, 3, 2);
    sendFrame(8, 4, 2, 1, 3, 2);
    drainOut("backpressure");
    checkCounts("backpressure", 12, 2);
  endtask

  task automatic test_clip();
    readyMode = 0;
    gapMode   = 1'b0;
    sendFrame(8, 4, 6, 1, 4, 2);
    drainOut("clip_right");
    checkCounts("clip_right", 4, 1);
    sendFrame(8, 4, 6, 3, 4, 4);
    drainOut("clip_bottom");
    checkCounts("clip_bottom", 2, 0);
    sendFrame(5, 3, 1, 1, 1023, 4095);
    drainOut("clip_wide");
    checkCounts("clip_wide", 8, 0);
  endtask

  task automatic test_restart();
    readyMode = 1;
    gapMode   = 1'b1;
    sendFrame(8, 4, 2, 1, 3, 2, 2, 3);
    sendFrame(8, 4, 0, 0, 2, 3);
    drainOut("restart");
    checkCounts("restart", 10, 1);
  endtask

  task automatic test_reset_midframe();
    readyMode = 2;
    gapMode   = 1'b0;
    @(posedge clk);
    #1;
    roiX = '0; roiY = '0; roiW = X_W'(8); roiH = Y_W'(4);
    sendBeat($urandom, 1'b1, 1'b0);
    sendBeat($urandom, 1'b0, 1'b0);
    testsRun++;
    if (inReady !== 1'b0 || outValid !== 1'b1) begin
      failCount++;
      $display("[TB] FAIL full_buffer: got rdy=%b v=%b, need rdy=0 v=1", inReady, outValid);
    end
    #2;
    rstN = 1'b0;
    #1;
    testsRun++;
    if (outValid !== 1'b0 || outData !== 32'h0 || outUser !== 1'b0 || outLast !== 1'b0 ||
        roiDone !== 1'b0 || inReady !== 1'b1) begin
      failCount++;
      $display("[TB] FAIL async_reset: got v=%b d=%h u=%b l=%b done=%b rdy=%b, need 0 0 0 0 0 1",
               outValid, outData, outUser, outLast, roiDone, inReady);
    end
    expQ.delete();
    outBeats  = 0;
    doneCount = 0;
    @(negedge clk);
    rstN = 1'b1;
    readyMode = 0;
    @(posedge clk);
    #1;
    for (int i = 0; i < 5; i++) sendBeat($urandom, 1'b0, (i == 2));
    sendFrame(8, 4, 1, 1, 4, 2);
    drainOut("post_reset");
    checkCounts("post_reset", 8, 1);
  endtask

  task automatic test_zero_size();
    readyMode   = 0;
    gapMode     = 1'b0;
    stallCycles = 0;
    sendFrame(8, 4, 2, 1, 0, 2);
    sendFrame(8, 4, 2, 1, 3, 0);
    drainOut("zero_size");
    testsRun++;
    if (stallCycles !== 0) begin
      failCount++;
      $display("[TB] FAIL zero_ready: tready low for %0d cycles, need 0", stallCycles);
    end
    checkCounts("zero_size", 0, 0);
  endtask

  task automatic test_back_to_back();
    readyMode   = 0;
    gapMode     = 1'b0;
    stallCycles = 0;
    for (int f = 0; f < 3; f++) begin
      sendFrame($urandom_range(2, 10), $urandom_range(1, 5), $urandom_range(0, 4),
                $urandom_range(0, 3), $urandom_range(1, 6), $urandom_range(1, 4));
    end
    drainOut("back_to_back");
    testsRun++;
    if (stallCycles !== 0) begin
      failCount++;
      $display("[TB] FAIL throughput: tready low for %0d cycles, need 0", stallCycles);
    end
    outBeats  = 0;
    doneCount = 0;
  endtask

  task automatic test_random();
    readyMode = 1;
    gapMode   = 1'b1;
    for (int f = 0; f < 8; f++) begin
      sendFrame($urandom_range(1, 12), $urandom_range(1, 6), $urandom_range(0, 12),
                $urandom_range(0, 6), $urandom_range(0, 6), $urandom_range(0, 4));
    end
    drainOut("random");
    outBeats  = 0;
    doneCount = 0;
  endtask

  initial begin
    test_reset();
    test_latency();
    test_basic();
    test_backpressure();
    test_clip();
    test_restart();
    test_reset_midframe();
    test_zero_size();
    test_back_to_back();
    test_random();
    $display("[TB] %0d tests run, %0d failed", testsRun, failCount);
    $finish;
  end

endmodule

// File: doc/gray_roi_crop_4ppc.md
# gray_roi_crop_4ppc

Crops a programmable rectangular region of interest from the 4-pixel-per-clock 8-bit grayscale AXI4-Stream video produced by the RGB-to-gray stage. It forwards only ROI beats, re-frames them as a self-contained sub-frame with its own start-of-frame (`tuser`) and end-of-line (`tlast`) markers, and feeds the MOSSE correlation-window front end. Full backpressure is supported through a two-entry skid buffer.

## Interface
Parameters:
- `X_W`, default 10: width of beat-column counters; 960 beats covers 3840 px.
- `Y_W`, default 12: width of line counters; covers 2160 lines.

Ports:
- `s_axis_video_aclk`, in, 1: single clock for the whole block.
- `s_axis_video_aresetn`, in, 1: reset. Asynchronous, active-low.
- `VIDEO_IN_tdata`, in, 32: four gray pixels; pixel 0 is in [7:0].
- `VIDEO_IN_tvalid`, `VIDEO_IN_tuser`, `VIDEO_IN_tlast`, in, 1 each: input AXIS flags. `tuser` marks SOF; `tlast` marks EOL.
- `VIDEO_IN_tready`, out, 1: input ready.
- `VIDEO_OUT_tdata`, out, 32: cropped pixels, same packing as input.
- `VIDEO_OUT_tvalid`, `VIDEO_OUT_tuser`, `VIDEO_OUT_tlast`, out, 1 each: output AXIS flags.
- `VIDEO_OUT_tready`, in, 1: downstream ready.
- `ROI_X`, in, X_W: ROI left edge, in beats (4-px aligned).
- `ROI_Y`, in, Y_W: ROI top line.
- `ROI_W`, in, X_W: ROI width, in beats.
- `ROI_H`, in, Y_W: ROI height, in lines.
- `roi_done`, out, 1: one-cycle pulse when the last ROI beat is accepted downstream.

## Operation
- Transfer happens when `tvalid && tready`. Only accepted input beats advance the counters.
- ROI registers are latched from `ROI_*` on every accepted `tuser` beat. Changing `ROI_*` mid-frame has no effect on the current frame.
- State machine:
  - WAIT_SOF (reset state): input beats are accepted and dropped until a `tuser` beat arrives. That beat is treated as col 0 / line 0, then the state moves to ACTIVE.
  - ACTIVE: `col` increments per beat. On `tlast`, `col` goes to 0 and `line` increments.
  - A `tuser` beat seen in ACTIVE restarts the frame immediately: col 0 / line 0, ROI re-latched, any partial output frame abandoned without a fake `tlast`.
- A beat is in the ROI when `ROI_X ≤ col < ROI_X+ROI_W` and `ROI_Y ≤ line < ROI_Y+ROI_H`. Compare using sums one bit wider than the operands, so there is no wrap-around.
- Output `tuser` is set on the first ROI beat of each frame.
- Output `tlast` is set when `col == ROI_X+ROI_W-1`, or when input `tlast` falls inside the ROI (right-edge clipping).
- If the ROI extends past the bottom of the frame, the output simply stops early. `roi_done` does not fire.
- `ROI_W==0` or `ROI_H==0`: nothing is emitted for that frame and `roi_done` does not fire.
- `roi_done` fires on the output handshake of the beat where `line == ROI_Y+ROI_H-1` and output `tlast` is set.
- `tdata` passes through bit-exact. No arithmetic is performed on pixel data.

## Timing
- Reset values: all `VIDEO_OUT_*` = 0, `roi_done` = 0, `VIDEO_IN_tready` = 1, state = WAIT_SOF, counters = 0, skid buffer empty.
- Latency: 1 cycle from input acceptance to `VIDEO_OUT_tvalid`, since the output is registered.
- Throughput: 1 beat/cycle while `VIDEO_OUT_tready` = 1.
- Skid buffer has two entries. `VIDEO_IN_tready` = NOT(both entries full), and is registered with no combinational path from `VIDEO_OUT_tready`.
- Dropped (non-ROI) beats never occupy the skid buffer. They are still accepted only when `VIDEO_IN_tready` = 1.
- Once `VIDEO_OUT_tvalid` is high, output data and flags hold stable until accepted.
- Simultaneous push and pop on a full buffer keeps occupancy unchanged and loses no beat.
- Asserting reset mid-frame clears everything asynchronously. After reset, the block waits for the next `tuser`.

## Structure
- Shared package `mosse_video_pkg` holds `PPC=4`, `PIX_W=8`, `BEAT_W=32`, and a struct typedef for {tdata, tuser, tlast}. Reuse it elsewhere in the tracker pipeline.
- Sub-module `axis_skid_buffer` (parameter `DATA_W`, 2 entries, async active-low reset). The crop top level holds the counters, the state machine and the ROI compare logic.

## Test plan
- Frame of 8 beats × 4 lines, ROI X=2 Y=1 W=3 H=2, `VIDEO_OUT_tready`=1 -> 6 output beats (cols 2–4 of lines 1–2). `tuser` on the first, `tlast` on beats 3 and 6, `roi_done` on beat 6, data matches source.
- Same stimulus with `VIDEO_OUT_tready` toggled by a random 50% pattern -> identical output sequence. No beat lost or duplicated, and flags stay stable while stalled.
- ROI X=6 W=4 on the 8-beat frame -> 2 beats per line, `tlast` from clipping on col 7. Same with ROI Y=3 H=4 -> 1 line emitted and `roi_done` never asserts.
- Second `tuser` injected at line 2 col 3 of a frame -> current output ends without `tlast`. The new frame starts at col 0 / line 0 with the newly latched ROI.
- Reset asserted mid-line with the buffer full -> outputs 0 asynchronously. Beats before the next `tuser` are dropped, and the following frame crops correctly.
- ROI_W=0 -> no output beats and no `roi_done`. `VIDEO_IN_tready` stays 1 for the whole frame.
